saber_mac_seq: RTL

- Sequencer and datapath for one Saber schoolbook polynomial multiply: acc(x) = a(x)·s(x) mod (x^N + 1), coefficients mod 2^13.
- Walks every (i, j) coefficient pair and drives external a, s and accumulator RAMs.
- Feeds a single shift-and-add MAC lane (Ri ± a·|s|, |s| ≤ 4) and writes results back.
- Sits between the key/matrix memories and the polynomial-vector controller, which pulses start and waits for done.

---
 rtl/saber_mac_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/saber_mac_seq.sv
// Saber schoolbook polynomial multiply sequencer: acc(x) = a(x)*s(x) mod (x^N + 1), mod 2^13.
// One (i, j) coefficient pair is issued per cycle into a two-stage shift-and-add MAC lane.
module saber_mac_seq #(
    parameter int N    = 256,
    parameter int LOGN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] a_rd_addr,
    input  logic [12:0]     a_rd_data,
    output logic [LOGN-1:0] s_rd_addr,
    input  logic [3:0]      s_rd_data,
    output logic [LOGN-1:0] acc_rd_addr,
    input  logic [12:0]     acc_rd_data,
    output logic            acc_wr_en,
    output logic [LOGN-1:0] acc_wr_addr,
    output logic [12:0]     acc_wr_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LOGN-1:0] IDX_ZERO = LOGN'(0);
    localparam logic [LOGN-1:0] IDX_ONE  = LOGN'(1);
    localparam logic [LOGN-1:0] IDX_LAST = LOGN'(N - 1);

    logic [1:0]      state_r, state_nxt_s;
    logic [LOGN-1:0] i_r, j_r, k_r, i_nxt_s, j_nxt_s;
    logic            busy_r, done_r;
    logic [LOGN:0]   sum_s;
    logic            wrap_s;
    logic            v1_r, wrap1_r, first1_r;
    logic [LOGN-1:0] k1_r;
    logic            wr_en_r;
    logic [LOGN-1:0] wr_addr_r;
    logic [12:0]     wr_data_r;
    logic [12:0]     m_s, ri_s, acc_nxt_s;
    logic            neg_s;

    // |s| * a for |s| in 0..4 using shifts and one add; magnitudes 5..7 saturate to 4
    function automatic logic [12:0] scale_a(input logic [12:0] a, input logic [2:0] mag);
        logic [12:0] r;
        case (mag)
            3'd0:    r = 13'd0;
            3'd1:    r = a;
            3'd2:    r = {a[11:0], 1'b0};
            3'd3:    r = a + {a[11:0], 1'b0};
            default: r = {a[10:0], 2'b00};
        endcase
        return r;
    endfunction

    // Next-state and issue counter logic: inner loop i, outer loop j
    always_comb begin
        state_nxt_s = state_r;
        i_nxt_s     = i_r;
        j_nxt_s     = j_r;
        case (state_r)
            ST_IDLE: begin
                i_nxt_s = IDX_ZERO;
                j_nxt_s = IDX_ZERO;
                if (start) state_nxt_s = ST_MAC;
                else       state_nxt_s = ST_IDLE;
            end
            ST_MAC: begin
                i_nxt_s = i_r + IDX_ONE;
                if (i_r == IDX_LAST) begin
                    // j holds at N-1 on the final issue rather than wrapping
                    if (j_r == IDX_LAST) state_nxt_s = ST_DRAIN;
                    else                 j_nxt_s = j_r + IDX_ONE;
                end else begin
                    j_nxt_s = j_r;
                end
            end
            ST_DRAIN: begin
                if (!v1_r) state_nxt_s = ST_DONE;
                else       state_nxt_s = ST_DRAIN;
            end
            ST_DONE: begin
                i_nxt_s     = IDX_ZERO;
                j_nxt_s     = IDX_ZERO;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                i_nxt_s     = IDX_ZERO;
                j_nxt_s     = IDX_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state, issue addresses and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            i_r     <= IDX_ZERO;
            j_r     <= IDX_ZERO;
            k_r     <= IDX_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            i_r     <= i_nxt_s;
            j_r     <= j_nxt_s;
            k_r     <= i_nxt_s + j_nxt_s;
            busy_r  <= (state_nxt_s == ST_MAC) || (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Carry out of i + j marks a wrapped term, which picks up the x^N = -1 sign flip
    assign sum_s  = {1'b0, i_r} + {1'b0, j_r};
    assign wrap_s = sum_s[LOGN];

    // Stage 1: tags that travel alongside the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            k1_r     <= IDX_ZERO;
            wrap1_r  <= 1'b0;
            first1_r <= 1'b0;
        end else begin
            v1_r     <= (state_r == ST_MAC);
            k1_r     <= k_r;
            wrap1_r  <= wrap_s;
            first1_r <= (j_r == IDX_ZERO);
        end
    end

    // MAC lane: the j = 0 pass ignores stale accumulator contents
    always_comb begin
        m_s       = scale_a(a_rd_data, s_rd_data[2:0]);
        ri_s      = 13'd0;
        neg_s     = s_rd_data[3] ^ wrap1_r;
        acc_nxt_s = 13'd0;
        if (first1_r) ri_s = 13'd0;
        else          ri_s = acc_rd_data;
        if (neg_s) acc_nxt_s = ri_s - m_s;
        else       acc_nxt_s = ri_s + m_s;
    end

    // Stage 2: accumulator write-back register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= IDX_ZERO;
            wr_data_r <= 13'd0;
        end else begin
            wr_en_r   <= v1_r;
            wr_addr_r <= k1_r;
            if (v1_r) wr_data_r <= acc_nxt_s;
            else      wr_data_r <= wr_data_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign a_rd_addr   = i_r;
    assign s_rd_addr   = j_r;
    assign acc_rd_addr = k_r;
    assign acc_wr_en   = wr_en_r;
    assign acc_wr_addr = wr_addr_r;
    assign acc_wr_data = wr_data_r;

endmodule
